mor1kx_spr_arbiter: RTL
=======================

MOR1KX_SPR_ARBITER -- requirements
Module: mor1kx_spr_arbiter

Interface
REQ-001 Parameter OPTION_SPR_TIMEOUT, default 16: number of BUS-state cycles without spr_bus_ack_i before abort (2..255).
REQ-002 Parameter OPTION_RR_RESET, default "DU": requester marked last-granted at reset, "DU" or "CPU".
REQ-003 Clock is clk and reset is rst; reset is asynchronous and active-high; single clock domain.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cpu_spr_req_i  input  1  pipeline SPR request; held high until cpu_spr_ack_o.
REQ-007 cpu_spr_we_i / cpu_spr_addr_i / cpu_spr_dat_i  input  1/16/32  pipeline write-enable, address, write data.
REQ-008 cpu_spr_ack_o  output  1  one-cycle completion pulse to pipeline.
REQ-009 cpu_spr_dat_o  output  32  read data, valid only while cpu_spr_ack_o is high, else 0.
REQ-010 du_spr_req_i / du_spr_we_i / du_spr_addr_i / du_spr_dat_i  input  1/1/16/32  debug-unit request, same rules as CPU.
REQ-011 du_spr_ack_o / du_spr_dat_o  output  1/32  debug-unit completion pulse and read data.
REQ-012 cfgrs_i  input  384  flattened config registers, slot k at [32k+31:32k]: VR,VR2,UPR,CPUCFGR,DMMUCFGR,IMMUCFGR,DCCFGR,ICCFGR,DCFGR,PCCFGR,FPCSR,AVR (k=0..11).
REQ-013 spr_bus_stb_o / spr_bus_we_o / spr_bus_addr_o / spr_bus_dat_o  output  1/1/16/32  shared SPR bus to other groups.
REQ-014 spr_bus_ack_i / spr_bus_dat_i  input  1/32  bus completion and read data.
REQ-015 bus_timeout_o  output  1  one-cycle pulse when a bus access is aborted.

Function
REQ-016 FSM states IDLE, LOCAL, BUS, DONE; exactly one transaction in flight.
REQ-017 IDLE: if any req high, grant and register we/addr/data of winner; go LOCAL if addr[15:11]==0, else BUS.
REQ-018 Arbitration round-robin: single requester always wins; both high -> requester not last granted wins; last-grant updates on every grant.
REQ-019 LOCAL (one cycle): assert winner ack; read data per map VR=0x0000, UPR=0x0001, CPUCFGR=0x0002, DMMUCFGR=0x0003, IMMUCFGR=0x0004, DCCFGR=0x0005, ICCFGR=0x0006, DCFGR=0x0007, PCCFGR=0x0008, VR2=0x0009, AVR=0x000A, FPCSR=0x0014; other group-0 addresses read 0.
REQ-020 Local latency: request sampled in IDLE at cycle N -> ack at N+1; local writes acked and discarded.
REQ-021 BUS: spr_bus_stb_o high with registered we/addr/data from first BUS cycle until spr_bus_ack_i sampled high; stb drops the cycle after.
REQ-022 On spr_bus_ack_i in cycle M: capture spr_bus_dat_i, winner ack with that data at M+1 (DONE-bound response cycle), bus signals low at M+1.
REQ-023 After any ack the FSM spends one DONE cycle (no grant) so the acked requester can drop req; next grant earliest at ack+1.
REQ-024 Non-winning requester's ack and data stay 0 throughout; spr_bus_*_o are 0 outside BUS.
REQ-025 spr_bus_ack_i outside BUS is ignored.

Reset
REQ-026 rst high asynchronously forces IDLE, last-grant per OPTION_RR_RESET, timeout counter 0, all outputs 0, including mid-BUS (stb drops immediately, no ack issued).
REQ-027 First grant is evaluated on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro MOR1KX_SPR_BUS_TIMEOUT_EN defined: BUS-cycle counter; reaching OPTION_SPR_TIMEOUT without ack drops stb, acks winner with data 0 next cycle, pulses bus_timeout_o with that ack; ack_i on the timeout cycle wins over timeout.
REQ-029 Macro undefined: no counter, BUS waits indefinitely, bus_timeout_o tied 0.

Verification
REQ-030 CPU reads 0x0001 with UPR slot=0x0000_0619 -> cpu_spr_ack_o one cycle after request, cpu_spr_dat_o=0x0000_0619.
REQ-031 CPU and DU request simultaneously after reset (OPTION_RR_RESET="DU") -> CPU acked first, DU granted after DONE; repeated tie alternates.
REQ-032 DU reads 0x2800, bus acks after 3 stb cycles with 0xDEAD_BEEF -> du_spr_ack_o next cycle, data 0xDEAD_BEEF, stb low.
REQ-033 Timeout macro defined, bus never acks -> stb high exactly 16 cycles, ack with data 0 plus bus_timeout_o pulse; macro undefined -> stb held indefinitely.
REQ-034 rst asserted in 2nd BUS cycle -> stb and all outputs 0 same cycle, no ack after release until a new request.

Source files
------------

// File: rtl/mor1kx_spr_arbiter.sv
// mor1kx_spr_arbiter
// Arbitrates SPR accesses from the pipeline (CPU) and the debug unit (DU).
// Group-0 configuration registers are answered locally from cfgrs_i; every
// other group is forwarded to the shared SPR bus. One transaction in flight.
// Optional feature macro: MOR1KX_SPR_BUS_TIMEOUT_EN aborts a bus access after
// OPTION_SPR_TIMEOUT unacknowledged BUS cycles (ack with data 0 and a
// bus_timeout_o pulse). Without it the bus access waits indefinitely.
module mor1kx_spr_arbiter #(
  parameter int unsigned OPTION_SPR_TIMEOUT = 16,
  parameter string       OPTION_RR_RESET    = "DU"
) (
  input  logic         clk,
  input  logic         rst,
  // pipeline port
  input  logic         cpu_spr_req_i,
  input  logic         cpu_spr_we_i,
  input  logic [15:0]  cpu_spr_addr_i,
  input  logic [31:0]  cpu_spr_dat_i,
  output logic         cpu_spr_ack_o,
  output logic [31:0]  cpu_spr_dat_o,
  // debug-unit port
  input  logic         du_spr_req_i,
  input  logic         du_spr_we_i,
  input  logic [15:0]  du_spr_addr_i,
  input  logic [31:0]  du_spr_dat_i,
  output logic         du_spr_ack_o,
  output logic [31:0]  du_spr_dat_o,
  // flattened configuration registers
  input  logic [383:0] cfgrs_i,
  // shared SPR bus
  output logic         spr_bus_stb_o,
  output logic         spr_bus_we_o,
  output logic [15:0]  spr_bus_addr_o,
  output logic [31:0]  spr_bus_dat_o,
  input  logic         spr_bus_ack_i,
  input  logic [31:0]  spr_bus_dat_i,
  output logic         bus_timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_BUS,
    ST_DONE
  } state_t;

  // Slot positions inside cfgrs_i
  localparam int unsigned SLOT_VR       = 0;
  localparam int unsigned SLOT_VR2      = 1;
  localparam int unsigned SLOT_UPR      = 2;
  localparam int unsigned SLOT_CPUCFGR  = 3;
  localparam int unsigned SLOT_DMMUCFGR = 4;
  localparam int unsigned SLOT_IMMUCFGR = 5;
  localparam int unsigned SLOT_DCCFGR   = 6;
  localparam int unsigned SLOT_ICCFGR   = 7;
  localparam int unsigned SLOT_DCFGR    = 8;
  localparam int unsigned SLOT_PCCFGR   = 9;
  localparam int unsigned SLOT_FPCSR    = 10;
  localparam int unsigned SLOT_AVR      = 11;

  // 1: DU counts as last granted out of reset, so the CPU wins the first tie
  localparam logic RR_RESET_DU = (OPTION_RR_RESET == "CPU") ? 1'b0 : 1'b1;

  state_t        state_q, state_d;
  logic          last_du_q, last_du_d;
  logic          win_du_q, win_du_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          du_ack_q, du_ack_d;
  logic [31:0]   cpu_dat_q, cpu_dat_d;
  logic [31:0]   du_dat_q, du_dat_d;
  logic          stb_q, stb_d;
  logic          bwe_q, bwe_d;
  logic [15:0]   baddr_q, baddr_d;
  logic [31:0]   bdat_q, bdat_d;

`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(OPTION_SPR_TIMEOUT - 1);
  logic [7:0]    cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  logic          gnt_any;
  logic          gnt_du;
  logic          sel_we;
  logic [15:0]   sel_addr;
  logic [31:0]   sel_dat;
  logic          sel_local;
  logic [31:0]   local_rdata;

  // Round-robin pick and mux of the winning request
  always_comb begin
    gnt_any   = cpu_spr_req_i | du_spr_req_i;
    gnt_du    = du_spr_req_i & (~cpu_spr_req_i | ~last_du_q);
    sel_we    = gnt_du ? du_spr_we_i   : cpu_spr_we_i;
    sel_addr  = gnt_du ? du_spr_addr_i : cpu_spr_addr_i;
    sel_dat   = gnt_du ? du_spr_dat_i  : cpu_spr_dat_i;
    sel_local = (sel_addr[15:11] == 5'd0);
  end

  // Group-0 read map; unmapped group-0 addresses read as zero
  always_comb begin
    local_rdata = '0;
    case (sel_addr[10:0])
      11'h000: local_rdata = cfgrs_i[SLOT_VR*32       +: 32];
      11'h001: local_rdata = cfgrs_i[SLOT_UPR*32      +: 32];
      11'h002: local_rdata = cfgrs_i[SLOT_CPUCFGR*32  +: 32];
      11'h003: local_rdata = cfgrs_i[SLOT_DMMUCFGR*32 +: 32];
      11'h004: local_rdata = cfgrs_i[SLOT_IMMUCFGR*32 +: 32];
      11'h005: local_rdata = cfgrs_i[SLOT_DCCFGR*32   +: 32];
      11'h006: local_rdata = cfgrs_i[SLOT_ICCFGR*32   +: 32];
      11'h007: local_rdata = cfgrs_i[SLOT_DCFGR*32    +: 32];
      11'h008: local_rdata = cfgrs_i[SLOT_PCCFGR*32   +: 32];
      11'h009: local_rdata = cfgrs_i[SLOT_VR2*32      +: 32];
      11'h00A: local_rdata = cfgrs_i[SLOT_AVR*32      +: 32];
      11'h014: local_rdata = cfgrs_i[SLOT_FPCSR*32    +: 32];
      default: local_rdata = '0;
    endcase
  end

  // Next-state and registered-output logic. Acks are registered so a local
  // access answers in the LOCAL cycle and a bus access answers in DONE.
  always_comb begin
    state_d   = state_q;
    last_du_d = last_du_q;
    win_du_d  = win_du_q;
    cpu_ack_d = 1'b0;
    du_ack_d  = 1'b0;
    cpu_dat_d = '0;
    du_dat_d  = '0;
    stb_d     = stb_q;
    bwe_d     = bwe_q;
    baddr_d   = baddr_q;
    bdat_d    = bdat_q;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          last_du_d = gnt_du;
          win_du_d  = gnt_du;
          if (sel_local) begin
            state_d   = ST_LOCAL;
            // local writes are acknowledged and dropped
            cpu_ack_d = ~gnt_du;
            du_ack_d  = gnt_du;
            cpu_dat_d = (~gnt_du & ~sel_we) ? local_rdata : '0;
            du_dat_d  = ( gnt_du & ~sel_we) ? local_rdata : '0;
          end else begin
            state_d = ST_BUS;
            stb_d   = 1'b1;
            bwe_d   = sel_we;
            baddr_d = sel_addr;
            bdat_d  = sel_dat;
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      ST_LOCAL: begin
        state_d = ST_DONE;
      end

      ST_BUS: begin
        if (spr_bus_ack_i) begin
          state_d   = ST_DONE;
          stb_d     = 1'b0;
          bwe_d     = 1'b0;
          baddr_d   = '0;
          bdat_d    = '0;
          cpu_ack_d = ~win_du_q;
          du_ack_d  = win_du_q;
          cpu_dat_d = win_du_q ? '0 : spr_bus_dat_i;
          du_dat_d  = win_du_q ? spr_bus_dat_i : '0;
        end
`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = ST_DONE;
          stb_d     = 1'b0;
          bwe_d     = 1'b0;
          baddr_d   = '0;
          bdat_d    = '0;
          cpu_ack_d = ~win_du_q;
          du_ack_d  = win_du_q;
          tmo_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
        bwe_d   = 1'b0;
        baddr_d = '0;
        bdat_d  = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_du_q <= RR_RESET_DU;
      win_du_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      du_ack_q  <= 1'b0;
      cpu_dat_q <= '0;
      du_dat_q  <= '0;
      stb_q     <= 1'b0;
      bwe_q     <= 1'b0;
      baddr_q   <= '0;
      bdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_du_q <= last_du_d;
      win_du_q  <= win_du_d;
      cpu_ack_q <= cpu_ack_d;
      du_ack_q  <= du_ack_d;
      cpu_dat_q <= cpu_dat_d;
      du_dat_q  <= du_dat_d;
      stb_q     <= stb_d;
      bwe_q     <= bwe_d;
      baddr_q   <= baddr_d;
      bdat_q    <= bdat_d;
    end
  end

`ifdef MOR1KX_SPR_BUS_TIMEOUT_EN
  // Bus timeout counter and abort pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus_timeout_o = tmo_q;
`else
  assign bus_timeout_o = 1'b0;
`endif

  assign cpu_spr_ack_o  = cpu_ack_q;
  assign cpu_spr_dat_o  = cpu_dat_q;
  assign du_spr_ack_o   = du_ack_q;
  assign du_spr_dat_o   = du_dat_q;
  assign spr_bus_stb_o  = stb_q;
  assign spr_bus_we_o   = bwe_q;
  assign spr_bus_addr_o = baddr_q;
  assign spr_bus_dat_o  = bdat_q;

endmodule
